tape_port: RTL and testbench

- I/O device behind port A1h, enabled by the address decoder's SEL_TAPE strobe (decoder IORQ path, A[7:0]=8'hA1).
- Plays back host-supplied bytes as a biphase-encoded tape-in level that the CPU polls.
- Measures CPU-driven tape-out level changes and reports pulse lengths to the host/testbench for recording.
- Sits between the CPU data bus and the emulator's tape file model.

---
 rtl/tape_pkg.sv | 32 +++
 rtl/tape_fifo.sv | 68 ++++++
 rtl/tape_port.sv | 178 +++++++++++++++++
 tb/tb_tape_port.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/tape_pkg.sv
// Shared definitions for the A1h tape port: serializer state encoding,
// status-byte bit positions and the decoder port address.
package tape_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_HALF1 = 2'd2,
      ST_HALF2 = 2'd3
   } tape_state_e;

   localparam int TAPE_BIT_IN = 0;
   localparam int UNDERRUN    = 5;
   localparam int EMPTY       = 6;
   localparam int BUSY        = 7;

   localparam logic [7:0] TAPE_PORT_ADDR = 8'hA1;

   function automatic logic [7:0] tape_status(input logic st_tape_in,
                                               input logic st_underrun,
                                               input logic st_empty,
                                               input logic st_busy);
      logic [7:0] s;
      s              = 8'h00;
      s[TAPE_BIT_IN] = st_tape_in;
      s[UNDERRUN]    = st_underrun;
      s[EMPTY]       = st_empty;
      s[BUSY]        = st_busy;
      return s;
   endfunction

endpackage

// File: rtl/tape_fifo.sv
// Synchronous FIFO for playback bytes. Push and pop in the same cycle keep the
// occupancy unchanged even when full or empty (empty case passes data through).
module tape_fifo #(
   parameter int DEPTH_LOG2 = 2,
   parameter int WIDTH      = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [WIDTH-1:0]      mem_d [DEPTH];
   logic                  do_push, do_pop;

   assign full    = (count_q == DEPTH_CNT);
   assign empty   = (count_q == '0);
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && (!empty || push);
   assign rd_data = empty ? wr_data : mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge CLK) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/tape_port.sv
// Tape I/O device at port A1h: biphase playback of host bytes on tape-in and
// pulse-length measurement of CPU-driven tape-out for recording.
module tape_port
   import tape_pkg::*;
#(
   parameter logic [15:0] HALF_PERIOD     = 16'd250,
   parameter int          FIFO_DEPTH_LOG2 = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        SEL_TAPE,
   input  logic        RD,
   input  logic        WR,
   input  logic [7:0]  DI,
   output logic [7:0]  DO,
   input  logic [7:0]  PB_DATA,
   input  logic        PB_VALID,
   output logic        PB_READY,
   output logic [15:0] REC_LEN,
   output logic        REC_LEVEL,
   output logic        REC_VALID,
   output tape_state_e DBG_STATE
);

   tape_state_e state_q, state_d;
   logic [7:0]  shift_q, shift_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [15:0] half_cnt_q, half_cnt_d;
   logic        underrun_q, underrun_d;
   logic        tape_out_q, tape_out_d;
   logic [15:0] rec_cnt_q, rec_cnt_d;
   logic [15:0] rec_len_q, rec_len_d;
   logic        rec_level_q, rec_level_d;
   logic        rec_valid_q, rec_valid_d;

   logic        fifo_full, fifo_empty, fifo_pop, fifo_push;
   logic [7:0]  fifo_rdata;
   logic        underrun_set, half_done, tape_in, busy;
   logic        cpu_wr, cpu_rd;

   // Playback handshake: a byte transfers on any cycle where PB_VALID and
   // PB_READY are both high; PB_READY depends only on FIFO occupancy.
   assign PB_READY  = !fifo_full;
   assign fifo_push = PB_VALID && PB_READY;

   tape_fifo #(
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
      .WIDTH      (8)
   ) u_fifo (
      .CLK     (CLK),
      .RESET   (RESET),
      .push    (fifo_push),
      .wr_data (PB_DATA),
      .pop     (fifo_pop),
      .rd_data (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign half_done = (half_cnt_q == HALF_PERIOD - 16'd1);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= ST_IDLE;
         shift_q     <= 8'h00;
         bit_idx_q   <= 3'd0;
         half_cnt_q  <= 16'd0;
         underrun_q  <= 1'b0;
         tape_out_q  <= 1'b0;
         rec_cnt_q   <= 16'd0;
         rec_len_q   <= 16'd0;
         rec_level_q <= 1'b0;
         rec_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_idx_q   <= bit_idx_d;
         half_cnt_q  <= half_cnt_d;
         underrun_q  <= underrun_d;
         tape_out_q  <= tape_out_d;
         rec_cnt_q   <= rec_cnt_d;
         rec_len_q   <= rec_len_d;
         rec_level_q <= rec_level_d;
         rec_valid_q <= rec_valid_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bit_idx_d    = bit_idx_q;
      half_cnt_d   = half_cnt_q;
      underrun_set = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            shift_d    = fifo_rdata;
            bit_idx_d  = 3'd7;
            half_cnt_d = 16'd0;
            state_d    = ST_HALF1;
         end
         ST_HALF1: begin
            if (half_done) begin
               half_cnt_d = 16'd0;
               state_d    = ST_HALF2;
            end else begin
               half_cnt_d = half_cnt_q + 16'd1;
            end
         end
         ST_HALF2: begin
            if (half_done) begin
               half_cnt_d = 16'd0;
               if (bit_idx_q != 3'd0) begin
                  bit_idx_d = bit_idx_q - 3'd1;
                  shift_d   = {shift_q[6:0], 1'b0};
                  state_d   = ST_HALF1;
               end else if (!fifo_empty) begin
                  state_d = ST_LOAD;
               end else begin
                  underrun_set = 1'b1;
                  state_d      = ST_IDLE;
               end
            end else begin
               half_cnt_d = half_cnt_q + 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Biphase cell: first half carries the inverted bit, second half the bit.
   always_comb begin
      tape_in  = 1'b0;
      fifo_pop = (state_q == ST_LOAD);
      busy     = (state_q != ST_IDLE);
      case (state_q)
         ST_HALF1: tape_in = ~shift_q[7];
         ST_HALF2: tape_in = shift_q[7];
         default:  tape_in = 1'b0;
      endcase
   end

   assign cpu_wr = SEL_TAPE && WR;
   assign cpu_rd = SEL_TAPE && RD;

   always_comb begin
      tape_out_d  = cpu_wr ? DI[0] : tape_out_q;
      underrun_d  = underrun_q;
      if (cpu_wr && DI[7]) underrun_d = 1'b0;
      if (underrun_set)    underrun_d = 1'b1;

      rec_valid_d = 1'b0;
      rec_len_d   = rec_len_q;
      rec_level_d = rec_level_q;
      rec_cnt_d   = (rec_cnt_q == 16'hFFFF) ? rec_cnt_q : rec_cnt_q + 16'd1;
      // Only a real level change closes a pulse; rewriting the same level
      // keeps the pulse running.
      if (cpu_wr && (DI[0] != tape_out_q)) begin
         rec_valid_d = 1'b1;
         rec_len_d   = rec_cnt_q;
         rec_level_d = tape_out_q;
         rec_cnt_d   = 16'd1;
      end
   end

   always_comb begin
      DO = 8'h00;
      if (cpu_rd) DO = tape_status(tape_in, underrun_q, fifo_empty, busy);
   end

   assign REC_LEN   = rec_len_q;
   assign REC_LEVEL = rec_level_q;
   assign REC_VALID = rec_valid_q;
   assign DBG_STATE = state_q;

endmodule

// File: tb/tb_tape_port.sv
// Directed bench for tape_port: status reads, biphase playback, FIFO full,
// pulse recording with saturation, and reset in mid-byte.
module tb_tape_port;
   import tape_pkg::*;

   logic        CLK;
   logic        RESET;
   logic        SEL_TAPE;
   logic        RD;
   logic        WR;
   logic [7:0]  DI;
   logic [7:0]  DO;
   logic [7:0]  PB_DATA;
   logic        PB_VALID;
   logic        PB_READY;
   logic [15:0] REC_LEN;
   logic        REC_LEVEL;
   logic        REC_VALID;
   tape_state_e DBG_STATE;

   int errors = 0;
   int checks = 0;

   tape_port #(
      .HALF_PERIOD     (16'd4),
      .FIFO_DEPTH_LOG2 (2)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .SEL_TAPE  (SEL_TAPE),
      .RD        (RD),
      .WR        (WR),
      .DI        (DI),
      .DO        (DO),
      .PB_DATA   (PB_DATA),
      .PB_VALID  (PB_VALID),
      .PB_READY  (PB_READY),
      .REC_LEN   (REC_LEN),
      .REC_LEVEL (REC_LEVEL),
      .REC_VALID (REC_VALID),
      .DBG_STATE (DBG_STATE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      step();
      step();
      RESET = 1'b0;
   endtask

   task automatic write_cycle(input logic [7:0] d);
      WR = 1'b1;
      DI = d;
      step();
      WR = 1'b0;
      DI = 8'h00;
   endtask

   task automatic idle_no_strobe(input int n, input string tag);
      int seen;
      seen = 0;
      for (int i = 0; i < n; i++) begin
         step();
         if (REC_VALID === 1'b1) seen++;
      end
      chk(tag, 16'(seen), 16'd0);
   endtask

   initial begin
      logic [7:0] pat;
      logic [7:0] exp_do;
      logic       b;
      int         bad;

      RESET    = 1'b0;
      SEL_TAPE = 1'b1;
      RD       = 1'b1;
      WR       = 1'b0;
      DI       = 8'h00;
      PB_DATA  = 8'h00;
      PB_VALID = 1'b0;

      // Reset state and idle status
      do_reset();
      chk("rst_do", 16'(DO), 16'h0040);
      chk("rst_ready", 16'(PB_READY), 16'd1);
      chk("rst_rec_len", REC_LEN, 16'd0);
      chk("rst_rec_level", 16'(REC_LEVEL), 16'd0);
      chk("rst_rec_valid", 16'(REC_VALID), 16'd0);
      chk("rst_state", 16'(DBG_STATE), 16'(ST_IDLE));
      SEL_TAPE = 1'b0;
      #1;
      chk("unsel_do", 16'(DO), 16'h0000);
      SEL_TAPE = 1'b1;
      #1;
      idle_no_strobe(20, "rst_no_strobe");

      // Recorder: 20 cycles since reset, same-level rewrite, then 30-cycle pulse
      write_cycle(8'h01);
      chk("rec1_valid", 16'(REC_VALID), 16'd1);
      chk("rec1_len", REC_LEN, 16'd20);
      chk("rec1_level", 16'(REC_LEVEL), 16'd0);
      idle_no_strobe(9, "rec1_single");
      write_cycle(8'h01);
      chk("same_level_no_strobe", 16'(REC_VALID), 16'd0);
      idle_no_strobe(19, "rec_gap");
      write_cycle(8'h00);
      chk("rec2_valid", 16'(REC_VALID), 16'd1);
      chk("rec2_len", REC_LEN, 16'd30);
      chk("rec2_level", 16'(REC_LEVEL), 16'd1);
      step();
      chk("rec2_pulse_end", 16'(REC_VALID), 16'd0);

      // Counter saturation on a long hold
      idle_no_strobe(70000, "long_hold");
      chk("rec_len_held", REC_LEN, 16'd30);
      write_cycle(8'h01);
      chk("sat_valid", 16'(REC_VALID), 16'd1);
      chk("sat_len", REC_LEN, 16'hFFFF);
      chk("sat_level", 16'(REC_LEVEL), 16'd0);

      // Playback of A5, then underrun; clear attempt in the setting cycle loses
      do_reset();
      PB_DATA  = 8'hA5;
      PB_VALID = 1'b1;
      step();
      PB_VALID = 1'b0;
      step();
      chk("pb_load_state", 16'(DBG_STATE), 16'(ST_LOAD));
      chk("pb_load_do", 16'(DO), 16'h0080);
      pat = 8'hA5;
      for (int i = 0; i < 64; i++) begin
         step();
         b      = pat[7 - (i / 8)];
         exp_do = 8'hC0;
         exp_do[0] = ((i % 8) < 4) ? ~b : b;
         chk($sformatf("pb_bit_%0d", i), 16'(DO), 16'(exp_do));
         if (i == 63) begin
            WR = 1'b1;
            DI = 8'h80;
         end
      end
      step();
      WR = 1'b0;
      DI = 8'h00;
      chk("underrun_set_wins", 16'(DO), 16'h0060);
      chk("underrun_state", 16'(DBG_STATE), 16'(ST_IDLE));
      write_cycle(8'h80);
      chk("underrun_clear", 16'(DO), 16'h0040);

      // FIFO full while a byte is playing
      do_reset();
      PB_DATA  = 8'h11;
      PB_VALID = 1'b1;
      step();
      PB_VALID = 1'b0;
      steps(2);
      chk("full_first_half", 16'(DO), 16'h00C1);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("full_ready_%0d", k), 16'(PB_READY), 16'd1);
         PB_DATA  = 8'h20 + 8'(k);
         PB_VALID = 1'b1;
         step();
      end
      chk("full_not_ready", 16'(PB_READY), 16'd0);
      PB_DATA = 8'h99;
      step();
      PB_VALID = 1'b0;
      chk("full_fifth_ignored", 16'(PB_READY), 16'd0);
      steps(59);
      chk("full_load_state", 16'(DBG_STATE), 16'(ST_LOAD));
      chk("full_load_ready", 16'(PB_READY), 16'd0);
      step();
      chk("full_pop_ready", 16'(PB_READY), 16'd1);
      chk("full_next_byte_do", 16'(DO), 16'h0081);
      PB_DATA  = 8'h5A;
      PB_VALID = 1'b1;
      step();
      PB_VALID = 1'b0;
      chk("full_refill", 16'(PB_READY), 16'd0);

      // Reset in bit 3 of a byte with two more queued
      do_reset();
      for (int k = 0; k < 3; k++) begin
         PB_DATA  = (k == 0) ? 8'h34 : 8'hF0 + 8'(k);
         PB_VALID = 1'b1;
         step();
      end
      PB_VALID = 1'b0;
      steps(33);
      chk("mid_state", 16'(DBG_STATE), 16'(ST_HALF1));
      chk("mid_do", 16'(DO), 16'h0081);
      RESET = 1'b1;
      step();
      chk("mid_rst_do", 16'(DO), 16'h0040);
      chk("mid_rst_ready", 16'(PB_READY), 16'd1);
      chk("mid_rst_state", 16'(DBG_STATE), 16'(ST_IDLE));
      RESET = 1'b0;
      bad = 0;
      for (int i = 0; i < 80; i++) begin
         step();
         if (DO !== 8'h40) bad++;
      end
      chk("mid_rst_quiet", 16'(bad), 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
